// File: rtl/flght_sched.sv
// flght_sched: flight-mode sequencer in front of flght_cntrl.
// Runs the arming sequence: inertial calibration, soft thrust ramp, pilot
// pass-through in flight, and a controlled ramp-down on stop request or
// loss of inertial readings. Every output is registered.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   strt_cal       one-cycle arm/calibrate request
//   mtrs_off       one-cycle stop-motors request
//   cal_done       calibration-complete pulse from the inertial interface
//   vld            new inertial reading valid
//   thrst_cmd      commanded thrust (unsigned, 9 bit)
//   d_*_cmd        commanded pitch/roll/yaw (signed, 16 bit)
//   inertial_cal   motors at calibration speed
//   thrst          thrust to flght_cntrl
//   d_ptch/roll/yaw desired attitude to flght_cntrl
//   mtrs_en        motor drivers enabled
//   cal_err        sticky calibration-timeout flag
//   state          current state encoding
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | motors off, waiting for strt_cal
// CAL   | inertial calibration running, bounded by CAL_TMO clocks
// RAMP  | thrust climbs +1 every RAMP_DIV vld pulses toward thrst_cmd
// FLY   | pilot commands passed through with one clock of latency
// LAND  | thrust falls -1 every LAND_DIV clocks, then IDLE
// FAULT | calibration timed out; motors off, cal_err held until strt_cal
module flght_sched #(
  parameter int CAL_TMO  = 1000000,
  parameter int RAMP_DIV = 4,
  parameter int WDOG     = 500000,
  parameter int LAND_DIV = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               strt_cal,
  input  logic               mtrs_off,
  input  logic               cal_done,
  input  logic               vld,
  input  logic [8:0]         thrst_cmd,
  input  logic signed [15:0] d_ptch_cmd,
  input  logic signed [15:0] d_roll_cmd,
  input  logic signed [15:0] d_yaw_cmd,
  output logic               inertial_cal,
  output logic [8:0]         thrst,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic               mtrs_en,
  output logic               cal_err,
  output logic [2:0]         state
);

  localparam int CAL_W  = (CAL_TMO  > 1) ? $clog2(CAL_TMO)  : 1;
  localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WD_W   = (WDOG     > 1) ? $clog2(WDOG)     : 1;
  localparam int LAND_W = (LAND_DIV > 1) ? $clog2(LAND_DIV) : 1;

  localparam logic [CAL_W-1:0]  CAL_LAST  = CAL_W'(CAL_TMO - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WDOG - 1);
  localparam logic [LAND_W-1:0] LAND_LAST = LAND_W'(LAND_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAL   = 3'd1,
    RAMP  = 3'd2,
    FLY   = 3'd3,
    LAND  = 3'd4,
    FAULT = 3'd5,
    RSV6  = 3'd6,
    RSV7  = 3'd7
  } state_t;

  state_t             st, st_nxt;
  logic [CAL_W-1:0]   cal_cnt, cal_cnt_nxt;
  logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_cnt_nxt;
  logic [LAND_W-1:0]  land_cnt, land_cnt_nxt;
  logic [8:0]         thrst_nxt;
  logic signed [15:0] ptch_nxt, roll_nxt, yaw_nxt;
  logic               cal_err_nxt, ical_nxt, en_nxt, wd_exp;

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      thrst        <= '0;
      d_ptch       <= '0;
      d_roll       <= '0;
      d_yaw        <= '0;
      inertial_cal <= 1'b0;
      mtrs_en      <= 1'b0;
      cal_err      <= 1'b0;
      cal_cnt      <= '0;
      div_cnt      <= '0;
      wd_cnt       <= '0;
      land_cnt     <= '0;
    end else begin
      st           <= st_nxt;
      thrst        <= thrst_nxt;
      d_ptch       <= ptch_nxt;
      d_roll       <= roll_nxt;
      d_yaw        <= yaw_nxt;
      inertial_cal <= ical_nxt;
      mtrs_en      <= en_nxt;
      cal_err      <= cal_err_nxt;
      cal_cnt      <= cal_cnt_nxt;
      div_cnt      <= div_cnt_nxt;
      wd_cnt       <= wd_cnt_nxt;
      land_cnt     <= land_cnt_nxt;
    end
  end

  always_comb begin
    st_nxt       = st;
    thrst_nxt    = thrst;
    ptch_nxt     = d_ptch;
    roll_nxt     = d_roll;
    yaw_nxt      = d_yaw;
    cal_err_nxt  = cal_err;
    cal_cnt_nxt  = cal_cnt;
    div_cnt_nxt  = div_cnt;
    wd_cnt_nxt   = wd_cnt;
    land_cnt_nxt = land_cnt;
    wd_exp       = 1'b0;

    case (st)
      IDLE: begin
        if (strt_cal) begin
          st_nxt      = CAL;
          cal_cnt_nxt = '0;
        end
      end

      CAL: begin
        cal_cnt_nxt = cal_cnt + 1'b1;
        if (mtrs_off) begin
          st_nxt = IDLE;
        end else if (cal_done) begin
          st_nxt      = RAMP;
          div_cnt_nxt = '0;
          wd_cnt_nxt  = '0;
        end else if (cal_cnt == CAL_LAST) begin
          st_nxt      = FAULT;
          cal_err_nxt = 1'b1;
        end
      end

      RAMP, FLY: begin
        // A reading arriving on the last allowed clock still counts as
        // fresh, so expiry needs the count at its limit and no vld.
        wd_exp     = !vld && (wd_cnt == WD_LAST);
        wd_cnt_nxt = vld ? '0 : wd_cnt + 1'b1;
        if (mtrs_off || wd_exp) begin
          // Thrust is frozen at its current value; LAND ramps it down.
          st_nxt       = LAND;
          land_cnt_nxt = '0;
        end else if (st == FLY) begin
          thrst_nxt = thrst_cmd;
          ptch_nxt  = d_ptch_cmd;
          roll_nxt  = d_roll_cmd;
          yaw_nxt   = d_yaw_cmd;
        end else if (vld) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_nxt = '0;
            if (thrst < thrst_cmd) begin
              thrst_nxt = thrst + 1'b1;
            end else begin
              // Also catches a command lowered below the current thrust.
              thrst_nxt = thrst_cmd;
              st_nxt    = FLY;
              ptch_nxt  = d_ptch_cmd;
              roll_nxt  = d_roll_cmd;
              yaw_nxt   = d_yaw_cmd;
            end
          end else begin
            div_cnt_nxt = div_cnt + 1'b1;
          end
        end
      end

      LAND: begin
        if (thrst == '0) begin
          st_nxt = IDLE;
        end else if (land_cnt == LAND_LAST) begin
          land_cnt_nxt = '0;
          thrst_nxt    = thrst - 1'b1;
          // Leave on the same edge the last step lands at zero.
          if (thrst == 9'd1) st_nxt = IDLE;
        end else begin
          land_cnt_nxt = land_cnt + 1'b1;
        end
      end

      FAULT: begin
        if (strt_cal) begin
          st_nxt      = CAL;
          cal_cnt_nxt = '0;
          cal_err_nxt = 1'b0;
        end
      end

      default: st_nxt = IDLE;
    endcase

    // Outputs follow the state being entered so they change on the same edge.
    if (st_nxt != FLY) begin
      ptch_nxt = '0;
      roll_nxt = '0;
      yaw_nxt  = '0;
    end
    if (!(st_nxt inside {RAMP, FLY, LAND})) thrst_nxt = '0;
    ical_nxt = (st_nxt == CAL);
    en_nxt   = st_nxt inside {CAL, RAMP, FLY, LAND};
  end

endmodule

// File: tb/tb_flght_sched.sv
module tb_flght_sched;

  localparam int CAL_TMO  = 16;
  localparam int RAMP_DIV = 2;
  localparam int WDOG     = 32;
  localparam int LAND_DIV = 4;

  logic               clk = 1'b0;
  logic               rst, strt_cal, mtrs_off, cal_done, vld;
  logic [8:0]         thrst_cmd;
  logic signed [15:0] d_ptch_cmd, d_roll_cmd, d_yaw_cmd;
  logic               inertial_cal, mtrs_en, cal_err;
  logic [8:0]         thrst;
  logic signed [15:0] d_ptch, d_roll, d_yaw;
  logic [2:0]         state;

  int checks = 0;
  int errors = 0;

  flght_sched #(
    .CAL_TMO(CAL_TMO), .RAMP_DIV(RAMP_DIV), .WDOG(WDOG), .LAND_DIV(LAND_DIV)
  ) dut (
    .clk(clk), .rst(rst), .strt_cal(strt_cal), .mtrs_off(mtrs_off),
    .cal_done(cal_done), .vld(vld), .thrst_cmd(thrst_cmd),
    .d_ptch_cmd(d_ptch_cmd), .d_roll_cmd(d_roll_cmd), .d_yaw_cmd(d_yaw_cmd),
    .inertial_cal(inertial_cal), .thrst(thrst), .d_ptch(d_ptch),
    .d_roll(d_roll), .d_yaw(d_yaw), .mtrs_en(mtrs_en), .cal_err(cal_err),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] u16(input logic [15:0] x);
    return {16'h0, x};
  endfunction

  task automatic clr_in();
    rst = 0; strt_cal = 0; mtrs_off = 0; cal_done = 0; vld = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".state"}, 32'(state), 32'd0);
    chk({nm, ".thrst"}, 32'(thrst), 32'd0);
    chk({nm, ".d_ptch"}, u16(d_ptch), 32'd0);
    chk({nm, ".d_roll"}, u16(d_roll), 32'd0);
    chk({nm, ".d_yaw"}, u16(d_yaw), 32'd0);
    chk({nm, ".ical"}, 32'(inertial_cal), 32'd0);
    chk({nm, ".mtrs_en"}, 32'(mtrs_en), 32'd0);
    chk({nm, ".cal_err"}, 32'(cal_err), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       r, sc, mo, cd, v;
    logic [8:0] tc;
    logic [2:0] st;
    logic [8:0] th;
    logic       ic, en, er;
  } vec_t;

  function automatic vec_t mk(input logic r, sc, mo, cd, v, input int tc, st, th,
                              input logic ic, en, er);
    vec_t x;
    x.r = r; x.sc = sc; x.mo = mo; x.cd = cd; x.v = v;
    x.tc = 9'(tc); x.st = 3'(st); x.th = 9'(th);
    x.ic = ic; x.en = en; x.er = er;
    return x;
  endfunction

  vec_t tbl[17];

  // ---------------- reference model ----------------
  int          m_mode, m_thrst, m_cal_clks, m_pulses, m_quiet, m_land_from, m_land_clks;
  bit          m_err;
  logic [15:0] m_dp, m_dr, m_dy;

  task automatic model_reset();
    m_mode = 0; m_thrst = 0; m_cal_clks = 0; m_pulses = 0; m_quiet = 0;
    m_land_from = 0; m_land_clks = 0; m_err = 0;
    m_dp = '0; m_dr = '0; m_dy = '0;
  endtask

  // One clock of the sequencer described by its rules: clocks spent in CAL,
  // vld pulses spent in RAMP, clocks since the last reading, and thrust in
  // LAND as the entry value minus whole LAND_DIV periods elapsed.
  task automatic model_clk(input bit r, sc, mo, cd, v, input int tc,
                           input logic [15:0] dp, dr, dy);
    bit starved;
    if (r) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (sc) begin m_mode = 1; m_cal_clks = 0; end
      1: begin
        m_cal_clks++;
        if (mo) m_mode = 0;
        else if (cd) begin m_mode = 2; m_thrst = 0; m_pulses = 0; m_quiet = 0; end
        else if (m_cal_clks >= CAL_TMO) begin m_mode = 5; m_err = 1; end
      end
      2, 3: begin
        starved = !v && (m_quiet + 1 >= WDOG);
        m_quiet = v ? 0 : m_quiet + 1;
        if (mo || starved) begin
          m_mode = 4; m_land_from = m_thrst; m_land_clks = 0;
        end else if (m_mode == 3) begin
          m_thrst = tc; m_dp = dp; m_dr = dr; m_dy = dy;
        end else if (v) begin
          m_pulses++;
          if (m_pulses % RAMP_DIV == 0) begin
            if (m_thrst < tc) m_thrst++;
            else begin
              m_thrst = tc; m_mode = 3; m_dp = dp; m_dr = dr; m_dy = dy;
            end
          end
        end
      end
      4: begin
        m_land_clks++;
        if (m_land_from - m_land_clks / LAND_DIV <= 0) begin
          m_mode = 0; m_thrst = 0;
        end else begin
          m_thrst = m_land_from - m_land_clks / LAND_DIV;
        end
      end
      5: if (sc) begin m_mode = 1; m_cal_clks = 0; m_err = 0; end
      default: m_mode = 0;
    endcase
  endtask

  task automatic chk_model(input int n);
    bit flying, powered;
    string p;
    p = $sformatf("rnd%0d", n);
    flying  = (m_mode == 3);
    powered = (m_mode >= 2 && m_mode <= 4);
    chk({p, ".state"}, 32'(state), 32'(m_mode));
    chk({p, ".thrst"}, 32'(thrst), powered ? 32'(m_thrst) : 32'd0);
    chk({p, ".d_ptch"}, u16(d_ptch), flying ? u16(m_dp) : 32'd0);
    chk({p, ".d_roll"}, u16(d_roll), flying ? u16(m_dr) : 32'd0);
    chk({p, ".d_yaw"}, u16(d_yaw), flying ? u16(m_dy) : 32'd0);
    chk({p, ".ical"}, 32'(inertial_cal), 32'(m_mode == 1));
    chk({p, ".mtrs_en"}, 32'(mtrs_en), 32'(m_mode >= 1 && m_mode <= 4));
    chk({p, ".cal_err"}, 32'(cal_err), 32'(m_err));
  endtask

  initial begin
    int pulses;
    clr_in();
    thrst_cmd = '0; d_ptch_cmd = '0; d_roll_cmd = '0; d_yaw_cmd = '0;
    rst = 1;
    tick(); tick();
    chk_all_zero("reset");
    rst = 0;

    // ---------------- table-driven vectors ----------------
    //            r  sc mo cd v  tc   st th  ic en er
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0,   1, 0,  1, 1, 0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 0,   0, 0,  0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0,   1, 0,  1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0,   2, 0,  0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0,   2, 0,  0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0,   3, 0,  0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 5,   3, 5,  0, 1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 9,   4, 5,  0, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 9,   4, 5,  0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 9,   4, 5,  0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 9,   4, 5,  0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 9,   4, 4,  0, 1, 0);
    tbl[13] = mk(1, 1, 0, 0, 0, 0,   0, 0,  0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0,   1, 0,  1, 1, 0);
    tbl[15] = mk(0, 0, 1, 0, 0, 0,   0, 0,  0, 0, 0);
    tbl[16] = mk(0, 0, 1, 0, 0, 0,   0, 0,  0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].r; strt_cal = tbl[i].sc; mtrs_off = tbl[i].mo;
      cal_done = tbl[i].cd; vld = tbl[i].v; thrst_cmd = tbl[i].tc;
      tick();
      chk($sformatf("vec%0d.state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d.thrst", i), 32'(thrst), 32'(tbl[i].th));
      chk($sformatf("vec%0d.ical", i), 32'(inertial_cal), 32'(tbl[i].ic));
      chk($sformatf("vec%0d.mtrs_en", i), 32'(mtrs_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d.cal_err", i), 32'(cal_err), 32'(tbl[i].er));
    end
    clr_in();

    // ---------------- nominal flight + watchdog ----------------
    rst = 1; tick(); rst = 0;
    thrst_cmd = 9'd10; d_ptch_cmd = -16'sd300; d_roll_cmd = 16'sd123; d_yaw_cmd = -16'sd7;
    strt_cal = 1; tick(); strt_cal = 0;
    chk("nom.cal_state", 32'(state), 32'd1);
    chk("nom.cal_ical", 32'(inertial_cal), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("nom.cal_ical%0d", i), 32'(inertial_cal), 32'd1);
    end
    cal_done = 1; tick(); cal_done = 0;
    chk("nom.ramp_state", 32'(state), 32'd2);
    chk("nom.ramp_ical", 32'(inertial_cal), 32'd0);
    pulses = 0;
    for (int i = 0; i < 200 && pulses < 22; i++) begin
      vld = (i % 4 == 0);
      tick();
      if (vld) begin
        pulses++;
        chk($sformatf("nom.p%0d.state", pulses), 32'(state), (pulses == 22) ? 32'd3 : 32'd2);
        chk($sformatf("nom.p%0d.thrst", pulses), 32'(thrst), 32'((pulses / 2 > 10) ? 10 : pulses / 2));
      end
      vld = 0;
    end
    chk("nom.pulses", 32'(pulses), 32'd22);
    tick();
    chk("nom.fly_ptch", u16(d_ptch), u16(-16'sd300));
    chk("nom.fly_roll", u16(d_roll), u16(16'sd123));
    chk("nom.fly_yaw", u16(d_yaw), u16(-16'sd7));
    d_ptch_cmd = 16'sd555; tick();
    chk("nom.fly_ptch2", u16(d_ptch), u16(16'sd555));
    vld = 1; tick(); vld = 0;
    for (int i = 0; i < WDOG - 1; i++) tick();
    chk("wd.before", 32'(state), 32'd3);
    tick();
    chk("wd.land", 32'(state), 32'd4);
    chk("wd.land_ptch", u16(d_ptch), 32'd0);
    chk("wd.land_roll", u16(d_roll), 32'd0);
    chk("wd.land_yaw", u16(d_yaw), 32'd0);
    chk("wd.land_thrst", 32'(thrst), 32'd10);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("land%0d.state", k), 32'(state), (k < 40) ? 32'd4 : 32'd0);
      chk($sformatf("land%0d.thrst", k), 32'(thrst), (k < 40) ? 32'(10 - k / 4) : 32'd0);
    end
    chk("land.mtrs_en", 32'(mtrs_en), 32'd0);

    // ---------------- calibration timeout ----------------
    strt_cal = 1; tick(); strt_cal = 0;
    for (int i = 0; i < CAL_TMO - 1; i++) tick();
    chk("tmo.before", 32'(state), 32'd1);
    tick();
    chk("tmo.state", 32'(state), 32'd5);
    chk("tmo.cal_err", 32'(cal_err), 32'd1);
    chk("tmo.mtrs_en", 32'(mtrs_en), 32'd0);
    mtrs_off = 1; tick(); mtrs_off = 0;
    chk("fault.mtrs_off", 32'(state), 32'd5);
    chk("fault.err_held", 32'(cal_err), 32'd1);
    strt_cal = 1; tick(); strt_cal = 0;
    chk("fault.restart", 32'(state), 32'd1);
    chk("fault.err_clr", 32'(cal_err), 32'd0);
    // cal_done on the timeout clock wins
    for (int i = 0; i < CAL_TMO - 1; i++) tick();
    cal_done = 1; tick(); cal_done = 0;
    chk("tmo.done_wins", 32'(state), 32'd2);
    chk("tmo.done_err", 32'(cal_err), 32'd0);
    mtrs_off = 1; tick(); mtrs_off = 0;
    chk("ramp.off", 32'(state), 32'd4);
    tick();
    chk("ramp.off_idle", 32'(state), 32'd0);

    // ---------------- mtrs_off at watchdog expiry ----------------
    thrst_cmd = 9'd0;
    strt_cal = 1; tick(); strt_cal = 0;
    cal_done = 1; tick(); cal_done = 0;
    vld = 1; tick(); tick(); vld = 0;
    chk("wdo.fly", 32'(state), 32'd3);
    thrst_cmd = 9'd7;
    vld = 1; tick(); vld = 0;
    for (int i = 0; i < WDOG - 1; i++) tick();
    chk("wdo.before", 32'(state), 32'd3);
    chk("wdo.before_thrst", 32'(thrst), 32'd7);
    mtrs_off = 1; thrst_cmd = 9'd99; tick(); mtrs_off = 0;
    chk("wdo.land", 32'(state), 32'd4);
    chk("wdo.thrst", 32'(thrst), 32'd7);
    for (int i = 0; i < 7 * LAND_DIV; i++) tick();
    chk("wdo.idle", 32'(state), 32'd0);

    // ---------------- command lowered mid-ramp, reset mid-LAND ----------------
    thrst_cmd = 9'd100; d_ptch_cmd = 16'sd42;
    strt_cal = 1; tick(); strt_cal = 0;
    cal_done = 1; tick(); cal_done = 0;
    for (int i = 0; i < 14; i++) begin vld = 1; tick(); end
    vld = 0;
    chk("low.t7_state", 32'(state), 32'd2);
    chk("low.t7_thrst", 32'(thrst), 32'd7);
    thrst_cmd = 9'd3;
    vld = 1; tick();
    chk("low.half_state", 32'(state), 32'd2);
    chk("low.half_thrst", 32'(thrst), 32'd7);
    tick(); vld = 0;
    chk("low.state", 32'(state), 32'd3);
    chk("low.thrst", 32'(thrst), 32'd3);
    mtrs_off = 1; tick(); mtrs_off = 0;
    chk("rml.land", 32'(state), 32'd4);
    chk("rml.thrst", 32'(thrst), 32'd3);
    tick(); tick();
    rst = 1; strt_cal = 1; tick(); rst = 0; strt_cal = 0;
    chk_all_zero("rml.reset");
    strt_cal = 1; tick(); strt_cal = 0;
    chk("rml.cal", 32'(state), 32'd1);
    chk("rml.ical", 32'(inertial_cal), 32'd1);
    chk("rml.en", 32'(mtrs_en), 32'd1);

    // ---------------- randomized against reference model ----------------
    thrst_cmd = 9'd5;
    for (int n = 0; n < 4000; n++) begin
      int vrate;
      vrate    = ((n / 500) % 2 == 1) ? 24 : 3;
      rst      = (n == 0) || ($urandom_range(699) == 0);
      strt_cal = ($urandom_range(5) == 0);
      mtrs_off = ($urandom_range(79) == 0);
      cal_done = ($urandom_range(9) == 0);
      vld      = ($urandom_range(vrate - 1) == 0);
      if ($urandom_range(15) == 0)
        thrst_cmd = ($urandom_range(3) == 0) ? 9'($urandom_range(511)) : 9'($urandom_range(12));
      d_ptch_cmd = 16'($urandom);
      d_roll_cmd = 16'($urandom);
      d_yaw_cmd  = 16'($urandom);
      model_clk(rst, strt_cal, mtrs_off, cal_done, vld, int'(thrst_cmd),
                d_ptch_cmd, d_roll_cmd, d_yaw_cmd);
      tick();
      chk_model(n);
    end
    clr_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
